fetch_stage: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction decoder in the pipelined core. Owns the PC, issues word requests to instruction memory over a request/response interface, and buffers returned instruction words in a small FIFO. Presents `{pc, inst}` pairs to decode with a valid/ready handshake. Squashes stale fetches on branch/jump redirects and stops fetching on halt.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage_fifo.sv | 80 ++++++++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
    localparam int          INST_W             = 32;
    localparam logic [31:0] FETCH_STRIDE       = 32'd4;

    typedef enum logic {
        MODE_RUN,
        MODE_HALTED
    } fetch_mode_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundles for the fetch stage: instruction-memory request/response and
// the {pc, inst} handshake towards decode.
interface fetch_imem_if;
    import fetch_stage_pkg::*;

    logic              req;
    logic              rdy;
    logic [31:0]       addr;
    logic              rsp;
    logic [INST_W-1:0] rdata;

    modport master (output req, output addr, input rdy, input rsp, input rdata);
    modport slave  (input req, input addr, output rdy, output rsp, output rdata);
endinterface

interface fetch_decode_if;
    import fetch_stage_pkg::*;

    logic              valid;
    logic              ready;
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;

    modport master (output valid, output inst, output pc, input ready);
    modport slave  (input valid, input inst, input pc, output ready);
endinterface

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO with flush; serves as the instruction buffer and as
// the in-flight PC queue. The head comes straight from storage flops.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] mem_d [0:DEPTH-1];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the push needs, so push-when-full is fine with a pop.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches under a credit
// limit, buffers returned words and hands {pc, inst} pairs to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter int          DEPTH      = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    fetch_imem_if.master   imem,
    fetch_decode_if.master dec,
    input  logic           i_redirect,
    input  logic [31:0]    i_redirect_pc,
    input  logic           i_halt
);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int PAIR_W = 32 + INST_W;

    fetch_mode_e       mode_q, mode_d;
    logic [31:0]       pc_q, pc_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic              pop;
    logic              credit_ok;
    logic              accept;
    logic              rsp_ok;
    logic              inst_push;
    logic              inst_empty;
    logic [CW-1:0]     inst_count;
    logic [PAIR_W-1:0] inst_head;
    logic              pcq_empty;
    logic [CW-1:0]     pcq_count;
    logic [31:0]       pcq_head;

    // The PC queue occupancy is the number of accepted, unreturned requests.
    assign credit_ok = (int'(pcq_count) + int'(inst_count) - int'(pop)) < DEPTH;
    assign imem.req  = (mode_q == MODE_RUN) & ~i_redirect & credit_ok & ~i_rst;
    assign imem.addr = pc_q;
    assign accept    = imem.req & imem.rdy;

    // A response with nothing in flight is a protocol error and is ignored.
    assign rsp_ok    = imem.rsp & ~pcq_empty;
    assign inst_push = rsp_ok & (discard_q == '0) & ~i_redirect;

    assign dec.valid = ~inst_empty & ~i_rst;
    assign pop       = dec.valid & dec.ready;
    assign dec.pc    = dec.valid ? inst_head[PAIR_W-1:INST_W] : '0;
    assign dec.inst  = dec.valid ? inst_head[INST_W-1:0]      : '0;

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (1'b0),
        .push      (accept),
        .push_data (pc_q),
        .pop       (rsp_ok),
        .head      (pcq_head),
        .count     (pcq_count),
        .empty     (pcq_empty)
    );

    fetch_fifo #(.WIDTH(PAIR_W), .DEPTH(DEPTH)) u_inst_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (i_redirect),
        .push      (inst_push),
        .push_data ({pcq_head, imem.rdata}),
        .pop       (pop),
        .head      (inst_head),
        .count     (inst_count),
        .empty     (inst_empty)
    );

    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        mode_d    = mode_q;
        if (i_redirect) begin
            pc_d      = word_align(i_redirect_pc);
            discard_d = pcq_count - CW'(rsp_ok);
        end else begin
            if (accept) begin
                pc_d = pc_q + FETCH_STRIDE;
            end
            if (rsp_ok && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
        end
        if (i_halt) begin
            mode_d = MODE_HALTED;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q      <= RESET_ADDR;
            discard_q <= '0;
            mode_q    <= MODE_RUN;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
            mode_q    <= mode_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model plus an
// expected-delivery queue of fetch addresses since the last redirect.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RST_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;

    fetch_imem_if   imem ();
    fetch_decode_if dec ();

    always #5 clk = ~clk;

    fetch_stage #(.RESET_ADDR(RST_ADDR), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .imem          (imem),
        .dec           (dec),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_halt        (halt)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          delivered = 0;
    int          acc_count = 0;
    int          first_valid_cyc = -1;
    logic [31:0] first_valid_pc = 32'h0;
    mreq_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc = RST_ADDR;
    bit          halted = 1'b0;
    bit          full_rate = 1'b0;
    bit          post_rst = 1'b0;
    bit          redir_watch = 1'b0;
    logic [31:0] redir_expect_pc = 32'h0;
    bit          hold_prev = 1'b0;
    logic [31:0] hold_pc = 32'h0;
    logic [31:0] hold_inst = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at negedge, observe 1 time unit later, update model.
    task automatic applyStimulus(input bit rst_in, input bit rdy_in, input bit ready_in,
                                 input bit redir_in, input logic [31:0] rpc_in, input bit halt_in);
        bit pop_now;
        bit acc_now;
        @(negedge clk);
        rst         = rst_in;
        imem.rdy    = rdy_in;
        dec.ready   = ready_in;
        redirect    = redir_in;
        redirect_pc = rpc_in;
        halt        = halt_in;
        if (!rst_in && pend.size() > 0 && pend[0].due <= cyc) begin
            imem.rsp   = 1'b1;
            imem.rdata = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem.rsp   = 1'b0;
            imem.rdata = 32'hDEAD_BEEF;
        end
        #1;
        if (rst_in) begin
            checkOutput("rst_req", {31'b0, imem.req}, 32'h0);
            checkOutput("rst_valid", {31'b0, dec.valid}, 32'h0);
            checkOutput("rst_inst", dec.inst, 32'h0);
            checkOutput("rst_pc", dec.pc, 32'h0);
            pend.delete();
            exp_q.delete();
            exp_pc          = RST_ADDR;
            halted          = 1'b0;
            hold_prev       = 1'b0;
            post_rst        = 1'b1;
            first_valid_cyc = -1;
            cyc             = -1;
        end else begin
            if (post_rst) begin
                checkOutput("post_rst_valid", {31'b0, dec.valid}, 32'h0);
                checkOutput("post_rst_req", {31'b0, imem.req}, 32'h1);
                post_rst = 1'b0;
            end
            if (hold_prev) begin
                checkOutput("hold_valid", {31'b0, dec.valid}, 32'h1);
                checkOutput("hold_pc", dec.pc, hold_pc);
                checkOutput("hold_inst", dec.inst, hold_inst);
            end
            if (dec.valid) begin
                if (first_valid_cyc < 0) begin
                    first_valid_cyc = cyc;
                    first_valid_pc  = dec.pc;
                end
                if (exp_q.size() == 0) checkOutput("unexpected_valid", {31'b0, dec.valid}, 32'h0);
                else                   checkOutput("o_pc", dec.pc, exp_q[0]);
                checkOutput("o_inst", dec.inst, mem_word(dec.pc));
                if (redir_watch && !redir_in) begin
                    checkOutput("redir_first_pc", dec.pc, redir_expect_pc);
                    redir_watch = 1'b0;
                end
            end
            if (full_rate) begin
                checkOutput("run_req", {31'b0, imem.req}, 32'h1);
                if (cyc >= 2) checkOutput("run_valid", {31'b0, dec.valid}, 32'h1);
            end
            if (halted)   checkOutput("halt_req", {31'b0, imem.req}, 32'h0);
            if (redir_in) checkOutput("redir_req", {31'b0, imem.req}, 32'h0);
            pop_now = dec.valid & ready_in;
            acc_now = imem.req & rdy_in;
            if (pop_now) begin
                delivered++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            hold_prev = dec.valid & ~ready_in & ~redir_in;
            hold_pc   = dec.pc;
            hold_inst = dec.inst;
            if (redir_in) begin
                exp_q.delete();
                exp_pc = {rpc_in[31:2], 2'b00};
            end
            if (acc_now) begin
                acc_count++;
                checkOutput("fetch_addr", imem.addr, exp_pc);
                pend.push_back('{exp_pc, cyc + mem_lat});
                exp_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
                checkOutput("credit_cap", {31'b0, exp_q.size() <= DEPTH}, 32'h1);
            end
            if (halt_in) halted = 1'b1;
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        int n;
        int acc_snap;
        int deliv_snap;
        imem.rdy   = 1'b0;
        imem.rsp   = 1'b0;
        imem.rdata = 32'h0;
        dec.ready  = 1'b0;
        $display("[TB] fetch_stage bench start");

        // Reset, then full-rate streaming with a 1-cycle memory.
        mem_lat = 1;
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        full_rate = 1'b1;
        repeat (12) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        full_rate = 1'b0;
        checkOutput("first_valid_cyc", 32'(first_valid_cyc), 32'd2);
        checkOutput("first_valid_pc", first_valid_pc, RST_ADDR);

        // Decode stall: requests must stop once DEPTH words are held.
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        acc_snap = acc_count;
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("stall_no_req", 32'(acc_count), 32'(acc_snap));
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect with two requests in flight on a 3-cycle memory.
        mem_lat = 3;
        n = 0;
        while (pend.size() != 2 && n < 20) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            n++;
        end
        checkOutput("inflight_two", {31'b0, pend.size() == 2}, 32'h1);
        redir_expect_pc = 32'h0000_0100;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
        redir_watch = 1'b1;
        repeat (15) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("redir_seen", {31'b0, redir_watch}, 32'h0);

        // PC wrap at the top of the address space.
        mem_lat = 1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFA, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // 3-cycle memory with a toggling ready and a bursty decoder.
        mem_lat = 3;
        deliv_snap = delivered;
        for (int i = 0; i < 60; i++)
            applyStimulus(1'b0, (i % 2) == 0, $urandom_range(0, 3) != 0, 1'b0, 32'h0, 1'b0);
        checkOutput("lat3_progress", {31'b0, (delivered - deliv_snap) >= 8}, 32'h1);

        // Randomised traffic with occasional redirects to arbitrary addresses.
        for (int i = 0; i < 200; i++) begin
            mem_lat = $urandom_range(1, 4);
            applyStimulus(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0, $urandom, 1'b0);
        end

        // Halt: in-flight words drain, no new requests, redirect issues nothing.
        mem_lat = 2;
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("halt_drained", 32'(exp_q.size()), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Reset leaves HALTED; then reset again in the middle of a stream.
        mem_lat = 1;
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
